// File: rtl/mac_feed_ctrl.sv
// rtl/mac_feed_ctrl.sv - operand-pair FIFO and sequencer feeding a MAC unit
//
// Buffers streamed (A,B) operand pairs and issues VEC_LEN of them to a MAC as one
// dot product: a clear, then one enable per pair. Once the last product has been
// accumulated, the MAC output is captured and held on a valid/ready result port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/b   operand pair input (in_ready = FIFO not full)
//   start                      begin one dot product (honoured in IDLE only)
//   busy                       sequencer not idle
//   mac_en/mac_clr/mac_a/b     registered MAC controls and operands
//   mac_cout                   MAC accumulator output
//   res_valid/res_ready        result handshake
//   res_data                   captured 3*DATA_WIDTH dot product
module mac_feed_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic                    start,
  output logic                    busy,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data
);

  localparam int DW = DATA_WIDTH;
  localparam int RW = 3 * DATA_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int VW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [VW-1:0] LAST_IDX = VW'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_DRAIN   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [2*DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fill;
  logic [VW-1:0]   count, count_nxt;
  logic            push, pop, empty;

  logic            mac_en_nxt, mac_clr_nxt, res_valid_nxt;
  logic [DW-1:0]   mac_a_nxt, mac_b_nxt;
  logic [RW-1:0]   res_data_nxt;

  assign empty    = (fill == '0);
  assign in_ready = (fill != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_FEED) && !empty;
  assign busy     = (state != S_IDLE);

  // Storage needs no reset: occupancy is tracked by fill, not by contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FEED;
      S_FEED:    if (pop && count == LAST_IDX) state_nxt = S_DRAIN;
      S_DRAIN:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    if (res_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; anything not assigned holds.
  always_comb begin
    mac_en_nxt    = mac_en;
    mac_clr_nxt   = mac_clr;
    mac_a_nxt     = mac_a;
    mac_b_nxt     = mac_b;
    res_valid_nxt = res_valid;
    res_data_nxt  = res_data;
    count_nxt     = count;
    case (state)
      S_IDLE: begin
        mac_en_nxt = 1'b0;
        if (start) begin
          mac_clr_nxt = 1'b1;
          count_nxt   = '0;
        end
      end
      S_FEED: begin
        mac_clr_nxt = 1'b0;
        if (pop) begin
          mac_en_nxt               = 1'b1;
          {mac_a_nxt, mac_b_nxt}   = mem[rd_ptr];
          count_nxt                = count + 1'b1;
        end else begin
          mac_en_nxt = 1'b0;
        end
      end
      // The MAC accumulates the final product on the edge that leaves DRAIN,
      // so mac_cout is only complete once we are in CAPTURE.
      S_DRAIN:   mac_en_nxt = 1'b0;
      S_CAPTURE: begin
        res_data_nxt  = mac_cout;
        res_valid_nxt = 1'b1;
      end
      S_DONE:    if (res_ready) res_valid_nxt = 1'b0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      count     <= '0;
    end else begin
      mac_en    <= mac_en_nxt;
      mac_clr   <= mac_clr_nxt;
      mac_a     <= mac_a_nxt;
      mac_b     <= mac_b_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      count     <= count_nxt;
    end
  end

endmodule

// File: tb/tb_mac_feed_ctrl.sv
// tb/tb_mac_feed_ctrl.sv - directed self-checking bench for mac_feed_ctrl
module tb_mac_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        mac_en;
  logic        mac_clr;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [23:0] mac_cout;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [23:0] res_data;

  logic [23:0] acc;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int s_cyc = 0;
  int clr_n = 0;
  int en_n = 0;
  int both_n = 0;

  mac_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .busy(busy),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_cout(mac_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: clear wins, otherwise accumulate when enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (mac_clr) acc <= '0;
    else if (mac_en)  acc <= acc + 24'(mac_a) * 24'(mac_b);
  end
  assign mac_cout = acc;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (mac_clr) clr_n++;
    if (mac_en) en_n++;
    if (mac_clr && mac_en) both_n++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    clr_n = 0;
    en_n = 0;
    both_n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_res(input int budget, output int lat);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    lat = res_valid ? (cyc - s_cyc) : -1;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    int pushed;
    logic exp_en;

    // 1: reset
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_mac_ab", {mac_a, mac_b}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    tick();

    // 2: prefilled dot product, sum of 50*i^2 = 10200
    for (int i = 1; i <= 8; i++) push_pair(8'(5 * i), 8'(10 * i));
    pulse_start();
    check("t2_clr_first", mac_clr, 1);
    wait_res(40, lat);
    check("t2_latency", lat, 10);
    check("t2_clr_cnt", clr_n, 1);
    check("t2_en_cnt", en_n, 8);
    check("t2_both", both_n, 0);
    check("t2_data", res_data, 24'h0027D8);
    accept();
    check("t2_valid_drop", res_valid, 0);
    check("t2_idle", busy, 0);

    // 3: full-scale operands
    for (int i = 0; i < 8; i++) push_pair(8'd255, 8'd255);
    pulse_start();
    wait_res(40, lat);
    check("t3_latency", lat, 10);
    check("t3_data", res_data, 24'h07F008);
    accept();

    // 4: start empty, one pair every 3 cycles (a=i, b=i+1 -> 240)
    pulse_start();
    pushed = 0;
    bad = 0;
    for (int n = 1; n <= 40 && !res_valid; n++) begin
      in_valid = (n % 3 == 1) && (pushed < 8);
      in_a = 8'(pushed + 1);
      in_b = 8'(pushed + 2);
      tick();
      if (in_valid) pushed++;
      in_valid = 1'b0;
      exp_en = (n % 3 == 2) && (n <= 23);
      if (mac_en !== exp_en) bad++;
    end
    lat = res_valid ? (cyc - s_cyc) : -1;
    check("t4_en_pattern", bad, 0);
    check("t4_en_cnt", en_n, 8);
    check("t4_latency", lat, 25);
    check("t4_data", res_data, 240);
    accept();

    // 5: fill to 8, 9th pair waits for a pop and stays for the next run
    for (int i = 1; i <= 8; i++) push_pair(8'(i), 8'd1);
    check("t5_full", in_ready, 0);
    clr_n = 0;
    en_n = 0;
    in_valid = 1'b1;
    in_a = 8'd100;
    in_b = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
    check("t5_full_at_start", in_ready, 0);
    tick();
    check("t5_ready_after_pop", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_res(40, lat);
    check("t5_latency", lat, 10);
    check("t5_data", res_data, 36);
    accept();
    for (int i = 0; i < 7; i++) push_pair(8'd1, 8'd2);
    pulse_start();
    wait_res(40, lat);
    check("t5_leftover_latency", lat, 10);
    check("t5_leftover_data", res_data, 114);
    accept();

    // 6: result held under back-pressure, start ignored in DONE
    for (int i = 0; i < 8; i++) push_pair(8'd2, 8'd3);
    pulse_start();
    wait_res(40, lat);
    check("t6_data", res_data, 48);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      tick();
      if (!(res_valid === 1'b1 && res_data === 24'd48 && busy === 1'b1)) bad++;
    end
    start = 1'b0;
    check("t6_hold_stable", bad, 0);
    accept();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_valid", res_valid, 0);
    tick();
    check("t6_no_restart", busy, 0);

    // reset mid-FEED
    for (int i = 0; i < 8; i++) push_pair(8'd1, 8'd1);
    pulse_start();
    tick();
    tick();
    check("rst_mid_feeding", mac_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_en", mac_en, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_ab", {mac_a, mac_b}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < 6; i++) tick();
    check("rst_mid_fifo_empty", en_n, 0);
    check("rst_mid_stalled", busy, 1);
    rst_n = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
